wb_cfg_loader: RTL and testbench

Boot-time configuration sequencer and bus owner for a Wishbone register bank. After reset, and on each `start_i` request, it writes a parameterised table of address/data pairs into the bank through its Wishbone master port. Outside load sequences it passes a host Wishbone master straight through to the bank. It sits between the host interconnect and one generated register block, so control registers hold known values before software touches them.

---
 rtl/wb_cfg_loader.sv | 219 +++++++++++++++++++++
 tb/tb_wb_cfg_loader.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cfg_loader.sv
// Boot-time configuration sequencer for a Wishbone register bank.
// Writes a fixed address/data table into the bank after reset and on request.
// Outside a load sequence it passes the host master straight through.
module wb_cfg_loader #(
    parameter int unsigned                  N_ENTRIES = 2,
    parameter int unsigned                  ADDR_W    = 3,
    parameter logic [N_ENTRIES*ADDR_W-1:0]  INIT_ADDR = {3'd4, 3'd0},
    parameter logic [N_ENTRIES*32-1:0]      INIT_DATA = {32'h0000_0123, 32'h0},
    parameter int unsigned                  TIMEOUT   = 15,
    parameter int unsigned                  MAX_RETRY = 3
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    // host side
    input  logic              h_cyc_i,
    input  logic              h_stb_i,
    input  logic              h_we_i,
    input  logic [ADDR_W-1:0] h_adr_i,
    input  logic [3:0]        h_sel_i,
    input  logic [31:0]       h_dat_i,
    output logic              h_ack_o,
    output logic              h_err_o,
    output logic              h_rty_o,
    output logic              h_stall_o,
    output logic [31:0]       h_dat_o,
    // bank side
    output logic              m_cyc_o,
    output logic              m_stb_o,
    output logic              m_we_o,
    output logic [ADDR_W-1:0] m_adr_o,
    output logic [3:0]        m_sel_o,
    output logic [31:0]       m_dat_o,
    input  logic              m_ack_i,
    input  logic              m_err_i,
    input  logic              m_rty_i,
    input  logic              m_stall_i,
    input  logic [31:0]       m_dat_i,
    // status
    output logic              busy_o,
    output logic              done_o,
    output logic              fail_o,
    output logic [7:0]        err_cnt_o
);

    localparam int unsigned IDX_W = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned DAT_W = 32;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_ENTRIES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RETRY_MAX = CNT_W'(MAX_RETRY);
    localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        LOAD = 2'd1,
        GAP  = 2'd2,
        HOST = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   retry_cnt;
    logic [CNT_W-1:0]   tmo_cnt;
    logic               adv_q;
    logic               start_pend;

    logic               tmo_hit;
    logic               can_retry;
    logic               ev_ok;
    logic               ev_retry;
    logic               ev_fail;
    logic               ev_any;

    logic [ADDR_W-1:0]  tbl_adr [N_ENTRIES];
    logic [DAT_W-1:0]   tbl_dat [N_ENTRIES];

    // Unpack the flat parameter tables into indexable arrays.
    for (genvar k = 0; k < N_ENTRIES; k++) begin : g_tbl
        assign tbl_adr[k] = INIT_ADDR[k*ADDR_W +: ADDR_W];
        assign tbl_dat[k] = INIT_DATA[k*DAT_W +: DAT_W];
    end

    // Classify the bank response for the current attempt (err > rty > ack > timeout).
    always_comb begin
        tmo_hit   = (tmo_cnt == TMO_LAST);
        can_retry = (retry_cnt < RETRY_MAX);
        ev_retry  = m_rty_i & ~m_err_i & can_retry;
        ev_ok     = m_ack_i & ~m_err_i & ~m_rty_i;
        ev_fail   = m_err_i | (m_rty_i & ~can_retry) | (~m_ack_i & ~m_rty_i & tmo_hit);
        ev_any    = ev_ok | ev_retry | ev_fail;
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            BOOT: state_nxt = LOAD;
            LOAD: if (ev_any) state_nxt = GAP;
            GAP: begin
                if (adv_q && (idx == LAST_IDX)) state_nxt = HOST;
                else                            state_nxt = LOAD;
            end
            HOST: if ((start_i | start_pend) & ~h_cyc_i) state_nxt = BOOT;
            default: state_nxt = BOOT;
        endcase
    end

    // Bus outputs: table write in LOAD, host pass-through in HOST, idle otherwise.
    always_comb begin
        m_cyc_o   = 1'b0;
        m_stb_o   = 1'b0;
        m_we_o    = 1'b0;
        m_adr_o   = '0;
        m_sel_o   = 4'h0;
        m_dat_o   = '0;
        h_ack_o   = 1'b0;
        h_err_o   = 1'b0;
        h_rty_o   = 1'b0;
        h_stall_o = h_cyc_i & h_stb_i;
        h_dat_o   = m_dat_i;
        case (state)
            LOAD: begin
                m_cyc_o = 1'b1;
                m_stb_o = 1'b1;
                m_we_o  = 1'b1;
                m_sel_o = 4'hF;
                m_adr_o = tbl_adr[idx];
                m_dat_o = tbl_dat[idx];
            end
            HOST: begin
                m_cyc_o   = h_cyc_i;
                m_stb_o   = h_stb_i;
                m_we_o    = h_we_i;
                m_adr_o   = h_adr_i;
                m_sel_o   = h_sel_i;
                m_dat_o   = h_dat_i;
                h_ack_o   = m_ack_i;
                h_err_o   = m_err_i;
                h_rty_o   = m_rty_i;
                h_stall_o = m_stall_i;
            end
            default: ;
        endcase
    end

    // Sequencer datapath: entry index, retry/timeout counters, status flags.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            idx        <= '0;
            retry_cnt  <= '0;
            tmo_cnt    <= '0;
            adv_q      <= 1'b0;
            start_pend <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            fail_o     <= 1'b0;
            err_cnt_o  <= '0;
        end else begin
            case (state)
                BOOT: begin
                    idx        <= '0;
                    retry_cnt  <= '0;
                    tmo_cnt    <= '0;
                    adv_q      <= 1'b0;
                    start_pend <= 1'b0;
                    busy_o     <= 1'b1;
                    done_o     <= 1'b0;
                    fail_o     <= 1'b0;
                    err_cnt_o  <= '0;
                end
                LOAD: begin
                    if (ev_any) begin
                        adv_q <= ~ev_retry;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                    if (ev_retry) begin
                        retry_cnt <= retry_cnt + CNT_W'(1);
                    end
                    if (ev_fail) begin
                        fail_o <= 1'b1;
                        if (err_cnt_o != CNT_SAT) err_cnt_o <= err_cnt_o + CNT_W'(1);
                    end
                end
                GAP: begin
                    tmo_cnt <= '0;
                    if (adv_q) begin
                        retry_cnt <= '0;
                        if (idx == LAST_IDX) begin
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                HOST: begin
                    // Hold a start that arrives mid host cycle until the cycle closes.
                    if (state_nxt == BOOT)          start_pend <= 1'b0;
                    else if (start_i && h_cyc_i)    start_pend <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cfg_loader.sv
// Directed bench for wb_cfg_loader with a small scripted bank responder.
module tb_wb_cfg_loader;

    localparam int unsigned ADDR_W = 3;
    localparam int M_ACK      = 0;
    localparam int M_STALL    = 1;
    localparam int M_TMO_ERR  = 2;
    localparam int M_RTY      = 3;
    localparam int M_ERR_HANG = 4;
    localparam logic [31:0] BANK_RD = 32'hCAFE_F00D;

    logic              clk = 1'b0;
    logic              rst_n_i;
    logic              start_i;
    logic              h_cyc_i, h_stb_i, h_we_i;
    logic [ADDR_W-1:0] h_adr_i;
    logic [3:0]        h_sel_i;
    logic [31:0]       h_dat_i;
    logic              h_ack_o, h_err_o, h_rty_o, h_stall_o;
    logic [31:0]       h_dat_o;
    logic              m_cyc_o, m_stb_o, m_we_o;
    logic [ADDR_W-1:0] m_adr_o;
    logic [3:0]        m_sel_o;
    logic [31:0]       m_dat_o;
    logic              m_ack_i, m_err_i, m_rty_i, m_stall_i;
    logic [31:0]       m_dat_i;
    logic              busy_o, done_o, fail_o;
    logic [7:0]        err_cnt_o;

    int total = 0;
    int bad   = 0;
    int mode  = M_ACK;
    int stall_run = 0;
    logic clr = 1'b0;

    // monitor state
    logic [ADDR_W-1:0] adr_q [$];
    logic [31:0]       dat_q [$];
    logic [3:0]        sel_q [$];
    int cyc0 = 0, cyc4 = 0, rise0 = 0, rise4 = 0, unstable = 0;
    logic              prev_stb = 1'b0;
    logic [ADDR_W-1:0] prev_adr = '0;
    logic [31:0]       prev_dat = '0;
    logic [3:0]        prev_sel = '0;

    always #5 clk = ~clk;

    wb_cfg_loader #(.TIMEOUT(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .start_i(start_i),
        .h_cyc_i(h_cyc_i), .h_stb_i(h_stb_i), .h_we_i(h_we_i),
        .h_adr_i(h_adr_i), .h_sel_i(h_sel_i), .h_dat_i(h_dat_i),
        .h_ack_o(h_ack_o), .h_err_o(h_err_o), .h_rty_o(h_rty_o),
        .h_stall_o(h_stall_o), .h_dat_o(h_dat_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
        .m_adr_o(m_adr_o), .m_sel_o(m_sel_o), .m_dat_o(m_dat_o),
        .m_ack_i(m_ack_i), .m_err_i(m_err_i), .m_rty_i(m_rty_i),
        .m_stall_i(m_stall_i), .m_dat_i(m_dat_i),
        .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o), .err_cnt_o(err_cnt_o)
    );

    // Scripted bank: responds combinationally to an active request.
    always_comb begin
        m_ack_i   = 1'b0;
        m_err_i   = 1'b0;
        m_rty_i   = 1'b0;
        m_stall_i = 1'b0;
        if (m_cyc_o && m_stb_o) begin
            case (mode)
                M_ACK:      m_ack_i = 1'b1;
                M_STALL:    if (stall_run < 3) m_stall_i = 1'b1; else m_ack_i = 1'b1;
                M_TMO_ERR:  if (m_adr_o != 3'd0) m_err_i = 1'b1;
                M_RTY:      m_rty_i = 1'b1;
                M_ERR_HANG: if (m_adr_o == 3'd0) m_err_i = 1'b1;
                default:    ;
            endcase
        end
    end

    // Bank-side activity log.
    always @(posedge clk) begin
        stall_run <= (m_cyc_o && m_stb_o) ? stall_run + 1 : 0;
        if (clr) begin
            adr_q.delete();
            dat_q.delete();
            sel_q.delete();
            cyc0 <= 0; cyc4 <= 0; rise0 <= 0; rise4 <= 0; unstable <= 0;
        end else begin
            if (m_cyc_o && m_stb_o && !m_stall_i && m_ack_i) begin
                adr_q.push_back(m_adr_o);
                dat_q.push_back(m_dat_o);
                sel_q.push_back(m_sel_o);
            end
            if (m_stb_o && m_adr_o == 3'd0) cyc0 <= cyc0 + 1;
            if (m_stb_o && m_adr_o == 3'd4) cyc4 <= cyc4 + 1;
            if (m_stb_o && !prev_stb && m_adr_o == 3'd0) rise0 <= rise0 + 1;
            if (m_stb_o && !prev_stb && m_adr_o == 3'd4) rise4 <= rise4 + 1;
            if (m_stb_o && prev_stb &&
                (m_adr_o != prev_adr || m_dat_o != prev_dat || m_sel_o != prev_sel))
                unstable <= unstable + 1;
        end
        prev_stb <= m_stb_o;
        prev_adr <= m_adr_o;
        prev_dat <= m_dat_o;
        prev_sel <= m_sel_o;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    // Optionally pulse start, then count edges until a load runs and finishes.
    task automatic run_wait(input bit with_start, output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        if (with_start) start_i = 1'b1;
        while (n < 100) begin
            @(posedge clk);
            #1;
            start_i = 1'b0;
            n++;
            if (busy_o) seen = 1'b1;
            if (seen && done_o) break;
        end
        if (!(seen && done_o)) n = -1;
        @(negedge clk);
    endtask

    function automatic logic [31:0] q_adr(input int i);
        return (adr_q.size() > i) ? 32'(adr_q[i]) : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] q_dat(input int i);
        return (dat_q.size() > i) ? dat_q[i] : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] q_sel(input int i);
        return (sel_q.size() > i) ? 32'(sel_q[i]) : 32'hDEAD_BEEF;
    endfunction

    initial begin
        int n;
        int acks0;
        bit found;

        rst_n_i = 1'b0;
        start_i = 1'b0;
        h_cyc_i = 1'b0; h_stb_i = 1'b0; h_we_i = 1'b0;
        h_adr_i = '0;   h_sel_i = '0;   h_dat_i = '0;
        m_dat_i = BANK_RD;
        mode    = M_ACK;
        clear_logs();
        repeat (2) @(negedge clk);

        // reset state
        chk("rst_m_cyc", 32'(m_cyc_o), 32'd0);
        chk("rst_m_stb", 32'(m_stb_o), 32'd0);
        chk("rst_busy",  32'(busy_o),  32'd0);
        chk("rst_done",  32'(done_o),  32'd0);
        chk("rst_err",   32'(err_cnt_o), 32'd0);

        // boot load, ack on first cycle
        rst_n_i = 1'b1;
        run_wait(1'b0, n);
        chk("t1_cycles", 32'(n), 32'd5);
        chk("t1_err",    32'(err_cnt_o), 32'd0);
        chk("t1_fail",   32'(fail_o), 32'd0);
        chk("t1_busy",   32'(busy_o), 32'd0);
        chk("t1_nacks",  32'(adr_q.size()), 32'd2);
        chk("t1_adr0",   q_adr(0), 32'd0);
        chk("t1_dat0",   q_dat(0), 32'h0);
        chk("t1_sel0",   q_sel(0), 32'hF);
        chk("t1_adr1",   q_adr(1), 32'd4);
        chk("t1_dat1",   q_dat(1), 32'h123);
        chk("t1_sel1",   q_sel(1), 32'hF);

        // host pass-through in HOST
        h_cyc_i = 1'b1; h_stb_i = 1'b1; h_we_i = 1'b1;
        h_adr_i = 3'd6; h_sel_i = 4'h5; h_dat_i = 32'h1234_5678;
        #1;
        chk("pt_m_cyc",  32'(m_cyc_o), 32'd1);
        chk("pt_m_adr",  32'(m_adr_o), 32'd6);
        chk("pt_m_sel",  32'(m_sel_o), 32'h5);
        chk("pt_m_dat",  m_dat_o, 32'h1234_5678);
        chk("pt_h_ack",  32'(h_ack_o), 32'd1);
        chk("pt_h_dat",  h_dat_o, BANK_RD);
        @(negedge clk);
        h_cyc_i = 1'b0; h_stb_i = 1'b0; h_we_i = 1'b0;

        // stall for 3 cycles, then ack
        mode = M_STALL;
        clear_logs();
        run_wait(1'b1, n);
        acks0 = 0;
        foreach (adr_q[i]) if (adr_q[i] == 3'd0) acks0++;
        chk("t2_cycles",   32'(n), 32'd12);
        chk("t2_nacks",    32'(adr_q.size()), 32'd2);
        chk("t2_ack0",     32'(acks0), 32'd1);
        chk("t2_cyc0",     32'(cyc0), 32'd4);
        chk("t2_unstable", 32'(unstable), 32'd0);
        chk("t2_err",      32'(err_cnt_o), 32'd0);

        // entry 0 times out, entry 1 errs
        mode = M_TMO_ERR;
        clear_logs();
        run_wait(1'b1, n);
        chk("t3_cycles", 32'(n), 32'd9);
        chk("t3_cyc0",   32'(cyc0), 32'd4);
        chk("t3_cyc4",   32'(cyc4), 32'd1);
        chk("t3_err",    32'(err_cnt_o), 32'd2);
        chk("t3_fail",   32'(fail_o), 32'd1);
        chk("t3_done",   32'(done_o), 32'd1);
        chk("t3_busy",   32'(busy_o), 32'd0);

        // retry on every attempt
        mode = M_RTY;
        clear_logs();
        run_wait(1'b1, n);
        chk("t4_cycles", 32'(n), 32'd18);
        chk("t4_att0",   32'(rise0), 32'd4);
        chk("t4_att4",   32'(rise4), 32'd4);
        chk("t4_err",    32'(err_cnt_o), 32'd2);
        chk("t4_fail",   32'(fail_o), 32'd1);

        // start during an open host cycle
        mode = M_ACK;
        h_cyc_i = 1'b1; h_stb_i = 1'b1; h_we_i = 1'b1;
        h_adr_i = 3'd2; h_sel_i = 4'h3; h_dat_i = 32'hA5A5_0001;
        start_i = 1'b1;
        #1;
        chk("t5_pt_adr", 32'(m_adr_o), 32'd2);
        chk("t5_pt_ack", 32'(h_ack_o), 32'd1);
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t5_hold_busy", 32'(busy_o), 32'd0);
            chk("t5_hold_cyc",  32'(m_cyc_o), 32'd1);
            @(negedge clk);
        end
        h_cyc_i = 1'b0; h_stb_i = 1'b0; h_we_i = 1'b0;
        @(negedge clk);
        chk("t5_boot_busy", 32'(busy_o), 32'd0);
        chk("t5_boot_cyc",  32'(m_cyc_o), 32'd0);
        @(negedge clk);
        chk("t5_load_busy", 32'(busy_o), 32'd1);
        chk("t5_load_done", 32'(done_o), 32'd0);
        chk("t5_load_adr",  32'(m_adr_o), 32'd0);
        h_cyc_i = 1'b1; h_stb_i = 1'b1; h_adr_i = 3'd5;
        start_i = 1'b1;
        #1;
        chk("t5_h_stall", 32'(h_stall_o), 32'd1);
        chk("t5_h_ack",   32'(h_ack_o), 32'd0);
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done_o) break;
            @(negedge clk);
        end
        chk("t5_done",     32'(done_o), 32'd1);
        chk("t5_served",   32'(h_ack_o), 32'd1);
        chk("t5_srv_adr",  32'(m_adr_o), 32'd5);
        h_cyc_i = 1'b0; h_stb_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_no_queue", 32'(busy_o), 32'd0);
        chk("t5_err",      32'(err_cnt_o), 32'd0);
        chk("t5_fail",     32'(fail_o), 32'd0);

        // reset during LOAD of entry 1
        mode = M_ERR_HANG;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (m_stb_o && m_adr_o == 3'd4) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("t6_reach",   32'(found), 32'd1);
        chk("t6_pre_err", 32'(err_cnt_o), 32'd1);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("t6_rst_cyc",  32'(m_cyc_o), 32'd0);
        chk("t6_rst_err",  32'(err_cnt_o), 32'd0);
        chk("t6_rst_busy", 32'(busy_o), 32'd0);
        mode = M_ACK;
        clear_logs();
        rst_n_i = 1'b1;
        run_wait(1'b0, n);
        chk("t6_cycles", 32'(n), 32'd5);
        chk("t6_adr0",   q_adr(0), 32'd0);
        chk("t6_err",    32'(err_cnt_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
